// File: rtl/reg_lock_dispatcher_pkg.sv
// Shared types for the issue pipeline: decoded instruction format,
// register file geometry and the dispatcher FSM encoding.
package maverickOne_pkg;

    localparam int NUM_REGS        = 32;
    localparam int NUM_OUTSTANDING = 4;
    localparam int TOTAL_FUNCS     = 8;
    localparam int REG_ADDR_W      = $clog2(NUM_REGS);
    localparam int FUNC_W          = $clog2(TOTAL_FUNCS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        reg_addr_t         rd;
        reg_addr_t         rs1;
        reg_addr_t         rs2;
        logic              blocking;
        logic              mem_op;
        logic [15:0]       imm;
    } decoded_instr_t;

    // FLOW: normal issue; DRAIN: hold everything until no write is outstanding
    typedef enum logic {
        FLOW  = 1'b0,
        DRAIN = 1'b1
    } disp_state_e;

endpackage

// File: rtl/reg_lock_dispatcher_if.sv
// Bundle of the dispatcher's handshake, writeback and lock signals.
// slave is the dispatcher's view, master is the surrounding pipeline's view.
interface reg_lock_dispatcher_if;
    import maverickOne_pkg::*;

    logic                clear_i;
    decoded_instr_t      instr_in_i;
    logic                instr_in_valid_i;
    logic                instr_in_ready_o;
    logic [NUM_REGS-1:0] locks_o;
    logic                wb_valid_i;
    reg_addr_t           wb_rd_i;
    decoded_instr_t      instr_out_o;
    logic                instr_out_valid_o;
    logic                instr_out_ready_i;
    logic                wb_underflow_o;

    modport slave (
        input  clear_i, instr_in_i, instr_in_valid_i, wb_valid_i, wb_rd_i,
               instr_out_ready_i,
        output instr_in_ready_o, locks_o, instr_out_o, instr_out_valid_o,
               wb_underflow_o
    );

    modport master (
        output clear_i, instr_in_i, instr_in_valid_i, wb_valid_i, wb_rd_i,
               instr_out_ready_i,
        input  instr_in_ready_o, locks_o, instr_out_o, instr_out_valid_o,
               wb_underflow_o
    );

endinterface

// File: rtl/reg_lock_dispatcher_lock_counter_bank.sv
// One saturating up/down outstanding-write counter per architectural
// register. Register 0 has no counter and is never locked.
module lock_counter_bank
    import maverickOne_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic                clear_i,
    input  logic                inc_en_i,
    input  reg_addr_t           inc_idx_i,
    input  logic                dec_en_i,
    input  reg_addr_t           dec_idx_i,
    output logic [NUM_REGS-1:0] cnt_max_o,
    output logic [NUM_REGS-1:0] locks_o,
    output logic                underflow_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REGS-1:0] uf_vec;

    assign cnt_max_o[0] = 1'b0;
    assign locks_o[0]   = 1'b0;
    assign uf_vec[0]    = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             inc_hit;
            logic             dec_hit;

            assign inc_hit = inc_en_i && (inc_idx_i == reg_addr_t'(gi));
            assign dec_hit = dec_en_i && (dec_idx_i == reg_addr_t'(gi));

            // Next count: simultaneous inc/dec cancel; saturate at both ends
            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (inc_hit && !dec_hit && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (dec_hit && !inc_hit && (cnt_q != '0)) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            // Counter state register
            always_ff @(posedge clk_i or negedge arst_ni) begin
                if (!arst_ni) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign uf_vec[gi]    = dec_hit && !inc_hit && (cnt_q == '0) && !clear_i;
            assign cnt_max_o[gi] = (cnt_q == CNT_MAX);
            assign locks_o[gi]   = |cnt_q;
        end
    endgenerate

    assign underflow_o = |uf_vec;

endmodule

// File: rtl/reg_lock_dispatcher.sv
// Dispatch stage: single-entry output register between the launcher and the
// execution units, register write locks, blocking-instruction drain and a
// one-deep memory-op limiter.
module reg_lock_dispatcher
    import maverickOne_pkg::*;
#(
    parameter int LOCK_CNT_W = $clog2(NUM_OUTSTANDING + 2)
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    reg_lock_dispatcher_if.slave bus
);

    disp_state_e         state_q, state_d;
    decoded_instr_t      out_q;
    logic                out_valid_q;
    logic                mem_busy_q;
    reg_addr_t           mem_rd_q;
    logic                uf_q;

    logic [NUM_REGS-1:0] cnt_max;
    logic [NUM_REGS-1:0] locks;
    logic                uf_pulse;
    logic                all_zero;
    logic                out_free;
    logic                fsm_ok;
    logic                mem_ok;
    logic                ready;
    logic                accept;
    reg_addr_t           in_rd;

    assign in_rd    = bus.instr_in_i.rd;
    assign all_zero = ~|locks;
    assign out_free = ~out_valid_q | bus.instr_out_ready_i;
    assign mem_ok   = ~(bus.instr_in_i.mem_op & mem_busy_q);
    // Ready is forced low while reset is held so nothing is taken mid-reset
    assign ready    = arst_ni & ~bus.clear_i & out_free & ~cnt_max[in_rd]
                    & fsm_ok & mem_ok;
    assign accept   = bus.instr_in_valid_i & ready;

    lock_counter_bank #(
        .CNT_W (LOCK_CNT_W)
    ) u_bank (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .clear_i     (bus.clear_i),
        .inc_en_i    (accept),
        .inc_idx_i   (in_rd),
        .dec_en_i    (bus.wb_valid_i & ~bus.clear_i),
        .dec_idx_i   (bus.wb_rd_i),
        .cnt_max_o   (cnt_max),
        .locks_o     (locks),
        .underflow_o (uf_pulse)
    );

    // Drain FSM: a blocking instruction waits until no write is outstanding
    always_comb begin
        state_d = state_q;
        fsm_ok  = 1'b0;
        case (state_q)
            FLOW: begin
                fsm_ok = ~bus.instr_in_i.blocking | all_zero;
                if (bus.instr_in_valid_i && bus.instr_in_i.blocking && !all_zero) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (all_zero) begin
                    state_d = FLOW;
                end
            end
            default: state_d = FLOW;
        endcase
        if (bus.clear_i) begin
            state_d = FLOW;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= FLOW;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register, memory-op tracking and sticky underflow flag
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            mem_busy_q  <= 1'b0;
            mem_rd_q    <= '0;
            uf_q        <= 1'b0;
        end else if (bus.clear_i) begin
            out_valid_q <= 1'b0;
            mem_busy_q  <= 1'b0;
        end else begin
            uf_q <= uf_q | uf_pulse;
            if (accept) begin
                out_q       <= bus.instr_in_i;
                out_valid_q <= 1'b1;
            end else if (bus.instr_out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (accept && bus.instr_in_i.mem_op) begin
                mem_busy_q <= 1'b1;
                mem_rd_q   <= in_rd;
            end else if (bus.wb_valid_i && mem_busy_q && (bus.wb_rd_i == mem_rd_q)) begin
                mem_busy_q <= 1'b0;
            end
        end
    end

    assign bus.instr_in_ready_o  = ready;
    assign bus.locks_o           = locks;
    assign bus.instr_out_o       = out_q;
    assign bus.instr_out_valid_o = out_valid_q;
    assign bus.wb_underflow_o    = uf_q;

endmodule

// File: tb/tb_reg_lock_dispatcher.sv
// Randomized bench for reg_lock_dispatcher with a behavioural model of
// the outstanding-write bookkeeping, drain rule and mem-op limit.
module tb_reg_lock_dispatcher;
    import maverickOne_pkg::*;

    localparam int LOCK_CNT_W = $clog2(NUM_OUTSTANDING + 2);
    localparam int CNT_MAX    = (1 << LOCK_CNT_W) - 1;

    logic clk;
    logic arst_n;

    reg_lock_dispatcher_if bus ();

    reg_lock_dispatcher #(
        .LOCK_CNT_W (LOCK_CNT_W)
    ) dut (
        .clk_i   (clk),
        .arst_ni (arst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared;
    int n_mismatched;

    // Reference model state
    int             cnt_m [NUM_REGS];
    bit             drain_m;
    bit             mem_busy_m;
    int             mem_rd_m;
    bit             out_valid_m;
    decoded_instr_t out_m;
    bit             uf_m;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) cnt_m[r] = 0;
        drain_m     = 0;
        mem_busy_m  = 0;
        mem_rd_m    = 0;
        out_valid_m = 0;
        out_m       = '0;
        uf_m        = 0;
    endtask

    function automatic bit all_zero_m();
        for (int r = 0; r < NUM_REGS; r++) begin
            if (cnt_m[r] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [NUM_REGS-1:0] exp_locks();
        logic [NUM_REGS-1:0] v;
        for (int r = 0; r < NUM_REGS; r++) v[r] = (cnt_m[r] != 0);
        return v;
    endfunction

    // Can the presented instruction be taken this cycle?
    function automatic bit exp_ready();
        int rd;
        rd = int'(bus.instr_in_i.rd);
        if (bus.clear_i) return 1'b0;
        if (out_valid_m && !bus.instr_out_ready_i) return 1'b0;
        if (cnt_m[rd] == CNT_MAX) return 1'b0;
        if (drain_m) return 1'b0;
        if (bus.instr_in_i.blocking && !all_zero_m()) return 1'b0;
        if (bus.instr_in_i.mem_op && mem_busy_m) return 1'b0;
        return 1'b1;
    endfunction

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        bit acc;
        bit az;
        int rd;
        int wrd;
        acc = bus.instr_in_valid_i && exp_ready();
        az  = all_zero_m();
        rd  = int'(bus.instr_in_i.rd);
        wrd = int'(bus.wb_rd_i);
        if (bus.clear_i) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_m[r] = 0;
            drain_m     = 0;
            mem_busy_m  = 0;
            out_valid_m = 0;
        end else begin
            if (drain_m) drain_m = !az;
            else if (bus.instr_in_valid_i && bus.instr_in_i.blocking && !az) drain_m = 1;
            for (int r = 1; r < NUM_REGS; r++) begin
                int d;
                d = 0;
                if (acc && rd == r) d++;
                if (bus.wb_valid_i && wrd == r) d--;
                if (d == 1) cnt_m[r]++;
                else if (d == -1) begin
                    if (cnt_m[r] == 0) uf_m = 1;
                    else cnt_m[r]--;
                end
            end
            if (acc && bus.instr_in_i.mem_op) begin
                mem_busy_m = 1;
                mem_rd_m   = rd;
            end else if (bus.wb_valid_i && mem_busy_m && wrd == mem_rd_m) begin
                mem_busy_m = 0;
            end
            if (acc) begin
                out_m       = bus.instr_in_i;
                out_valid_m = 1;
                $display("accept rd=%0d blocking=%0d mem_op=%0d at %0t",
                         rd, bus.instr_in_i.blocking, bus.instr_in_i.mem_op, $time);
            end else if (bus.instr_out_ready_i) begin
                out_valid_m = 0;
            end
        end
    endtask

    task automatic compare_all();
        if (bus.instr_in_valid_i) check_val("ready", bus.instr_in_ready_o, exp_ready());
        check_val("out_valid", bus.instr_out_valid_o, out_valid_m);
        if (out_valid_m) check_val("out_data", bus.instr_out_o, out_m);
        check_val("locks", bus.locks_o, exp_locks());
        check_val("underflow", bus.wb_underflow_o, uf_m);
    endtask

    // Check at the falling edge, update the model, move to just after the next rise
    task automatic step();
        @(negedge clk);
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.clear_i           = 1'b0;
        bus.instr_in_i        = '0;
        bus.instr_in_valid_i  = 1'b0;
        bus.wb_valid_i        = 1'b0;
        bus.wb_rd_i           = '0;
        bus.instr_out_ready_i = 1'b1;
    endtask

    task automatic drive_instr(input int rd, input bit blocking, input bit mem_op);
        decoded_instr_t ins;
        logic [63:0]    r;
        r            = {$urandom, $urandom};
        ins          = r[$bits(decoded_instr_t)-1:0];
        ins.rd       = reg_addr_t'(rd);
        ins.blocking = blocking;
        ins.mem_op   = mem_op;
        drive_idle();
        bus.instr_in_i       = ins;
        bus.instr_in_valid_i = 1'b1;
    endtask

    task automatic drive_random();
        decoded_instr_t ins;
        logic [63:0]    r;
        r  = {$urandom, $urandom};
        ins = r[$bits(decoded_instr_t)-1:0];
        ins.rd = ($urandom_range(0, 9) == 0) ? reg_addr_t'($urandom_range(8, 31))
                                             : reg_addr_t'($urandom_range(0, 7));
        ins.blocking = ($urandom_range(0, 39) == 0);
        ins.mem_op   = ($urandom_range(0, 6) == 0);
        bus.instr_in_i        = ins;
        bus.instr_in_valid_i  = ($urandom_range(0, 3) != 0);
        bus.instr_out_ready_i = ($urandom_range(0, 3) != 0);
        bus.wb_valid_i        = ($urandom_range(0, 2) == 0);
        bus.wb_rd_i           = ($urandom_range(0, 9) == 0) ? reg_addr_t'($urandom_range(8, 31))
                                                            : reg_addr_t'($urandom_range(0, 7));
        bus.clear_i           = ($urandom_range(0, 59) == 0);
    endtask

    initial begin
        decoded_instr_t first;
        n_compared   = 0;
        n_mismatched = 0;
        model_reset();

        // Reset held for 100ns with an instruction already presented
        arst_n = 1'b0;
        drive_instr(5, 1'b0, 1'b0);
        #100;
        check_val("rst_ready", bus.instr_in_ready_o, 1'b0);
        check_val("rst_valid", bus.instr_out_valid_o, 1'b0);
        check_val("rst_locks", bus.locks_o, '0);
        check_val("rst_uf", bus.wb_underflow_o, 1'b0);

        // First cycle after release takes rd=5
        arst_n = 1'b1;
        #1;
        check_val("rel_ready", bus.instr_in_ready_o, 1'b1);
        first = bus.instr_in_i;
        model_step();
        @(posedge clk);
        #1;
        check_val("acc_valid", bus.instr_out_valid_o, 1'b1);
        check_val("acc_data", bus.instr_out_o, first);
        check_val("acc_lock", bus.locks_o, 32'h0000_0020);

        drive_idle();
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = 5'd5;
        step();
        check_val("wb_unlock", bus.locks_o, '0);

        // Same-cycle increment and decrement on r3
        drive_instr(3, 1'b0, 1'b0);
        step();
        drive_instr(3, 1'b0, 1'b0);
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = 5'd3;
        step();
        check_val("incdec_lock", bus.locks_o, 32'h0000_0008);
        drive_idle();
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = 5'd3;
        step();
        check_val("incdec_free", bus.locks_o, '0);

        // Underflow on r4, then a clear with r6 locked
        drive_instr(6, 1'b0, 1'b0);
        step();
        drive_idle();
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = 5'd4;
        step();
        check_val("uf_set", bus.wb_underflow_o, 1'b1);
        drive_idle();
        bus.clear_i = 1'b1;
        step();
        check_val("clr_locks", bus.locks_o, '0);
        check_val("clr_valid", bus.instr_out_valid_o, 1'b0);
        check_val("clr_uf", bus.wb_underflow_o, 1'b1);

        // Blocking instruction waits for r7 to drain
        drive_instr(7, 1'b0, 1'b0);
        step();
        drive_instr(9, 1'b1, 1'b0);
        step();
        drive_instr(2, 1'b0, 1'b0);
        #1;
        check_val("drain_nb_stall", bus.instr_in_ready_o, 1'b0);
        drive_instr(9, 1'b1, 1'b0);
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = 5'd7;
        step();
        drive_instr(9, 1'b1, 1'b0);
        #1;
        check_val("drain_zero_locks", bus.locks_o, '0);
        check_val("drain_still_stall", bus.instr_in_ready_o, 1'b0);
        step();
        check_val("drain_release", bus.instr_in_ready_o, 1'b1);
        step();
        drive_idle();
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = 5'd9;
        step();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive_random();
            step();
        end

        // Asynchronous reset in the middle of traffic
        drive_instr(5, 1'b0, 1'b0);
        arst_n = 1'b0;
        #2;
        check_val("mid_rst_ready", bus.instr_in_ready_o, 1'b0);
        check_val("mid_rst_valid", bus.instr_out_valid_o, 1'b0);
        check_val("mid_rst_data", bus.instr_out_o, '0);
        check_val("mid_rst_locks", bus.locks_o, '0);
        check_val("mid_rst_uf", bus.wb_underflow_o, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        model_reset();
        #1;
        compare_all();
        model_step();
        @(posedge clk);
        #1;

        for (int i = 0; i < 500; i++) begin
            drive_random();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
